// File: rtl/derivative_power_rule_seq.sv
// Sequential power-rule stage: d/dx(c*x^n) = (c*n)*x^(n-1), with c*n from an iterative shift-add multiplier.
// Optional saturation of coef_out on overflow is enabled by defining DERIV_SAT_EN.
module derivative_power_rule_seq #(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned EXP_W  = 4,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] coef_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  coef_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              ovf
);

  localparam int unsigned PROD_W = COEF_W + EXP_W;
  localparam int unsigned CNT_W  = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [COEF_W-1:0]   c_q, c_d;
  logic [EXP_W-1:0]    n_q, n_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0]    coef_out_q, coef_out_d;
  logic [EXP_W-1:0]    exp_out_q, exp_out_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;

  logic [PROD_W-1:0]   addend_c;
  logic [PROD_W-1:0]   prod_c;
  logic                ovf_c;
  logic [OUT_W-1:0]    coef_res_c;

  // One shift-add step; on the last iteration prod_c is the exact final product.
  assign addend_c = n_q[cnt_q] ? (PROD_W'(c_q) << cnt_q) : '0;
  assign prod_c   = acc_q + addend_c;

  if (OUT_W >= PROD_W) begin : g_no_ovf
    assign ovf_c = 1'b0;
  end else begin : g_ovf
    assign ovf_c = |prod_c[PROD_W-1:OUT_W];
  end

`ifdef DERIV_SAT_EN
  assign coef_res_c = ovf_c ? {OUT_W{1'b1}} : OUT_W'(prod_c);
`else
  assign coef_res_c = OUT_W'(prod_c);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      c_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      coef_out_q  <= '0;
      exp_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      coef_out_q  <= coef_out_d;
      exp_out_q   <= exp_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    n_d         = n_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    coef_out_d  = coef_out_q;
    exp_out_d   = exp_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d       = coef_in;
          n_d       = exp_in;
          acc_d     = '0;
          cnt_d     = '0;
          exp_out_d = (exp_in == '0) ? '0 : exp_in - EXP_W'(1);
          // Zero exponent: derivative is the constant 0, skip the multiplier.
          if (exp_in == '0) begin
            coef_out_d  = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = prod_c;
        if (cnt_q == CNT_W'(EXP_W - 1)) begin
          cnt_d       = '0;
          coef_out_d  = coef_res_c;
          ovf_d       = ovf_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign coef_out  = coef_out_q;
  assign exp_out   = exp_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_derivative_power_rule_seq.sv
// Directed bench for derivative_power_rule_seq; expected values are hand-computed products of c*n.
module tb_derivative_power_rule_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] coef_in;
  logic [3:0] exp_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] coef_out;
  logic [3:0] exp_out;
  logic       ovf;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  derivative_power_rule_seq #(.COEF_W(8), .EXP_W(4), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_in   (coef_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_out  (coef_out),
    .exp_out   (exp_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_out_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_in_ready(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] t3_coef;
    logic [7:0] b2b_c [3];
    logic [3:0] b2b_n [3];
    logic [7:0] b2b_co [3];
    logic [3:0] b2b_eo [3];
    int t_acc;
    int t_prev;

`ifdef DERIV_SAT_EN
    t3_coef = 8'd255;
`else
    t3_coef = 8'd184;
`endif
    b2b_c  = '{8'd5, 8'd0, 8'd13};
    b2b_n  = '{4'd3, 4'd6, 4'd1};
    b2b_co = '{8'd15, 8'd0, 8'd13};
    b2b_eo = '{4'd2, 4'd5, 4'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    coef_in   = '0;
    exp_in    = '0;
    repeat (3) step();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_coef_out", 32'(coef_out), 32'd0);
    check("rst_exp_out", 32'(exp_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();

    // T1: c=5, n=3, result 4 cycles after acceptance
    in_valid = 1'b1; coef_in = 8'd5; exp_in = 4'd3;
    step();
    in_valid = 1'b0;
    check("t1_in_ready_busy", 32'(in_ready), 32'd0);
    repeat (3) step();
    check("t1_not_early", 32'(out_valid), 32'd0);
    step();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_coef", 32'(coef_out), 32'd15);
    check("t1_exp", 32'(exp_out), 32'd2);
    check("t1_ovf", 32'(ovf), 32'd0);
    check("t1_in_ready_done", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_out_valid_clr", 32'(out_valid), 32'd0);
    check("t1_in_ready_idle", 32'(in_ready), 32'd1);

    // T2: c=9, n=0, result right after the accept edge
    in_valid = 1'b1; coef_in = 8'd9; exp_in = 4'd0;
    step();
    in_valid = 1'b0;
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_coef", 32'(coef_out), 32'd0);
    check("t2_exp", 32'(exp_out), 32'd0);
    check("t2_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_in_ready", 32'(in_ready), 32'd1);

    // T3: c=200, n=15, product 3000 overflows 8 bits
    in_valid = 1'b1; coef_in = 8'd200; exp_in = 4'd15;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_coef", 32'(coef_out), 32'(t3_coef));
    check("t3_exp", 32'(exp_out), 32'd14);
    check("t3_ovf", 32'(ovf), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // T4: c=7, n=2 held under back-pressure while busy inputs are ignored
    in_valid = 1'b1; coef_in = 8'd7; exp_in = 4'd2;
    step();
    in_valid = 1'b0;
    wait_out_valid("t4_wait_valid", 10);
    coef_in = 8'd1; exp_in = 4'd1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      step();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_coef", 32'(coef_out), 32'd14);
      check("t4_hold_exp", 32'(exp_out), 32'd1);
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_in_ready_idle", 32'(in_ready), 32'd1);
    check("t4_out_valid_clr", 32'(out_valid), 32'd0);

    // T5: reset in the middle of CALC, then a clean rerun
    in_valid = 1'b1; coef_in = 8'd3; exp_in = 4'd5;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_coef", 32'(coef_out), 32'd0);
    check("t5_rst_exp", 32'(exp_out), 32'd0);
    check("t5_rst_ovf", 32'(ovf), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; coef_in = 8'd3; exp_in = 4'd5;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("t5_out_valid", 32'(out_valid), 32'd1);
    check("t5_coef", 32'(coef_out), 32'd15);
    check("t5_exp", 32'(exp_out), 32'd4);
    out_ready = 1'b1;
    step();

    // T6: back-to-back terms, in_valid and out_ready held high
    in_valid = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      coef_in = b2b_c[k];
      exp_in  = b2b_n[k];
      wait_in_ready("t6_wait_ready", 10);
      step();
      t_acc = cyc;
      if (k == 2) in_valid = 1'b0;
      if (k > 0) check("t6_interval", 32'(t_acc - t_prev), 32'd6);
      t_prev = t_acc;
      wait_out_valid("t6_wait_valid", 10);
      check("t6_latency", 32'(cyc - t_acc), 32'd4);
      check("t6_coef", 32'(coef_out), 32'(b2b_co[k]));
      check("t6_exp", 32'(exp_out), 32'(b2b_eo[k]));
      check("t6_ovf", 32'(ovf), 32'd0);
    end
    step();
    check("t6_final_idle", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
